image_packer: RTL and testbench

Frame packer downstream of the camera interface. Consumes its 12-bit pixel stream and serial metadata record and emits a framed byte stream toward the JPEG/storage path:
- start marker, 6 metadata bytes, packed pixels (2 pixels → 3 bytes), end marker, 24-bit pixel count.
- A byte FIFO absorbs output back-pressure, since the camera side cannot be stalled.

---
 rtl/image_packer_if.sv | 13 +
 rtl/image_packer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_image_packer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/image_packer_if.sv
// rtl/image_packer_if.sv - packed byte stream toward the JPEG/storage path
interface image_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eof;

  modport master (output out_data, output out_valid, output out_sof, output out_eof,
                  input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_sof, input  out_eof,
                  output out_ready);
endinterface

// File: rtl/image_packer.sv
// rtl/image_packer.sv - frames camera metadata and 12-bit pixels into a byte stream
// Optional trailing CRC-8 byte when IMAGE_PACKER_CRC_EN is defined.
module image_packer #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic          sysClk,
  input  logic          sysRst_n,
  input  logic [11:0]   image_pixel_data,
  input  logic          image_data_valid,
  input  logic          image_metadata_line,
  input  logic          image_metadata_valid,
  input  logic          image_frame_end,
  input  logic          clear_flags,
  image_packer_if.master out_if,
  output logic          frame_active,
  output logic          fifo_overflow_flag,
  output logic          pixel_overrun_flag,
  output logic          sequence_error_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef IMAGE_PACKER_CRC_EN
  localparam logic [2:0] TAIL_LAST = 3'd5;
`else
  localparam logic [2:0] TAIL_LAST = 3'd4;
`endif

  typedef enum logic [2:0] {S_IDLE, S_META, S_HDR, S_PIX, S_TAIL} state_t;

  state_t      state, state_nxt;
  logic [47:0] meta, meta_nxt;
  logic [5:0]  meta_cnt, meta_cnt_nxt;
  logic [2:0]  hdr_idx, hdr_idx_nxt;
  logic [2:0]  tail_idx, tail_idx_nxt;
  logic [23:0] pix_cnt, pix_cnt_nxt;
  logic        half, half_nxt;
  logic [3:0]  nib, nib_nxt;
  logic        pend, pend_nxt;
  logic [7:0]  pend_byte, pend_byte_nxt;
  logic        last_acc, last_acc_nxt;
  logic        push;
  logic [9:0]  push_word;
  logic        seq_set, ovr_set;
  logic [7:0]  tail_byte;
  logic [7:0]  crc;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_push, do_pop, drop;
  logic [9:0]    head;

  always_comb begin
    tail_byte = 8'h00;
    case (tail_idx)
      3'd0:    tail_byte = 8'h5A;
      3'd1:    tail_byte = 8'hA5;
      3'd2:    tail_byte = pix_cnt[23:16];
      3'd3:    tail_byte = pix_cnt[15:8];
      3'd4:    tail_byte = pix_cnt[7:0];
      default: tail_byte = crc;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    meta_nxt      = meta;
    meta_cnt_nxt  = meta_cnt;
    hdr_idx_nxt   = hdr_idx;
    tail_idx_nxt  = tail_idx;
    pix_cnt_nxt   = pix_cnt;
    half_nxt      = half;
    nib_nxt       = nib;
    pend_nxt      = pend;
    pend_byte_nxt = pend_byte;
    last_acc_nxt  = 1'b0;
    push          = 1'b0;
    push_word     = 10'h000;
    seq_set       = 1'b0;
    ovr_set       = 1'b0;
    case (state)
      S_IDLE: begin
        if (image_data_valid || image_frame_end) seq_set = 1'b1;
        if (image_metadata_valid) begin
          meta_nxt     = {meta[46:0], image_metadata_line};
          meta_cnt_nxt = 6'd1;
          state_nxt    = S_META;
        end
      end
      S_META: begin
        if (image_data_valid) seq_set = 1'b1;
        if (image_frame_end) begin
          seq_set   = 1'b1;
          state_nxt = S_IDLE;
        end else if (image_metadata_valid) begin
          meta_nxt     = {meta[46:0], image_metadata_line};
          meta_cnt_nxt = meta_cnt + 6'd1;
          if (meta_cnt == 6'd47) begin
            state_nxt   = S_HDR;
            hdr_idx_nxt = 3'd0;
          end
        end
      end
      S_HDR: begin
        if (image_data_valid || image_metadata_valid || image_frame_end) seq_set = 1'b1;
        push = 1'b1;
        case (hdr_idx)
          3'd0:    push_word = {2'b01, 8'hA5};
          3'd1:    push_word = {2'b00, 8'h5A};
          3'd2:    push_word = {2'b00, meta[47:40]};
          3'd3:    push_word = {2'b00, meta[39:32]};
          3'd4:    push_word = {2'b00, meta[31:24]};
          3'd5:    push_word = {2'b00, meta[23:16]};
          3'd6:    push_word = {2'b00, meta[15:8]};
          default: push_word = {2'b00, meta[7:0]};
        endcase
        hdr_idx_nxt = hdr_idx + 3'd1;
        if (hdr_idx == 3'd7) begin
          state_nxt   = S_PIX;
          pix_cnt_nxt = 24'd0;
          half_nxt    = 1'b0;
          pend_nxt    = 1'b0;
        end
      end
      S_PIX: begin
        if (image_metadata_valid) seq_set = 1'b1;
        if (image_frame_end) begin
          if (image_data_valid) seq_set = 1'b1;
          if (pend) begin
            push      = 1'b1;
            push_word = {2'b00, pend_byte};
            pend_nxt  = 1'b0;
          end
          state_nxt    = S_TAIL;
          tail_idx_nxt = 3'd0;
        end else if (pend) begin
          // pend is only ever set by the strobe accepted last cycle
          push      = 1'b1;
          push_word = {2'b00, pend_byte};
          pend_nxt  = 1'b0;
          if (image_data_valid) ovr_set = 1'b1;
        end else if (image_data_valid) begin
          if (last_acc) begin
            ovr_set = 1'b1;
          end else begin
            last_acc_nxt = 1'b1;
            pix_cnt_nxt  = (pix_cnt == 24'hFFFFFF) ? pix_cnt : pix_cnt + 24'd1;
            push         = 1'b1;
            if (!half) begin
              push_word = {2'b00, image_pixel_data[11:4]};
              nib_nxt   = image_pixel_data[3:0];
              half_nxt  = 1'b1;
            end else begin
              push_word     = {2'b00, nib, image_pixel_data[11:8]};
              pend_nxt      = 1'b1;
              pend_byte_nxt = image_pixel_data[7:0];
              half_nxt      = 1'b0;
            end
          end
        end
      end
      S_TAIL: begin
        if (image_data_valid || image_metadata_valid || image_frame_end) seq_set = 1'b1;
        push = 1'b1;
        if (half) begin
          push_word = {2'b00, nib, 4'h0};
          half_nxt  = 1'b0;
        end else begin
          push_word    = {(tail_idx == TAIL_LAST), 1'b0, tail_byte};
          tail_idx_nxt = tail_idx + 3'd1;
          if (tail_idx == TAIL_LAST) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state     <= S_IDLE;
      meta      <= 48'h0;
      meta_cnt  <= 6'd0;
      hdr_idx   <= 3'd0;
      tail_idx  <= 3'd0;
      pix_cnt   <= 24'd0;
      half      <= 1'b0;
      nib       <= 4'h0;
      pend      <= 1'b0;
      pend_byte <= 8'h00;
      last_acc  <= 1'b0;
    end else begin
      state     <= state_nxt;
      meta      <= meta_nxt;
      meta_cnt  <= meta_cnt_nxt;
      hdr_idx   <= hdr_idx_nxt;
      tail_idx  <= tail_idx_nxt;
      pix_cnt   <= pix_cnt_nxt;
      half      <= half_nxt;
      nib       <= nib_nxt;
      pend      <= pend_nxt;
      pend_byte <= pend_byte_nxt;
      last_acc  <= last_acc_nxt;
    end
  end

`ifdef IMAGE_PACKER_CRC_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h07;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // Dropped bytes still feed the CRC so the receiver can detect the loss
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n)             crc <= 8'h00;
    else if (state == S_IDLE)  crc <= 8'h00;
    else if (push)             crc <= crc8_byte(crc, push_word[7:0]);
  end
`else
  assign crc = 8'h00;
`endif

  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign drop    = push && full;
  assign do_pop  = out_if.out_valid && out_if.out_ready;

  always_ff @(posedge sysClk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head             = mem[rd_ptr];
  assign out_if.out_valid = (count != '0);
  assign out_if.out_data  = out_if.out_valid ? head[7:0] : 8'h00;
  assign out_if.out_sof   = out_if.out_valid & head[8];
  assign out_if.out_eof   = out_if.out_valid & head[9];
  assign frame_active     = (state != S_IDLE);

  // A set event in the same cycle as clear_flags wins
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      fifo_overflow_flag  <= 1'b0;
      pixel_overrun_flag  <= 1'b0;
      sequence_error_flag <= 1'b0;
    end else begin
      fifo_overflow_flag  <= drop    | (fifo_overflow_flag  & ~clear_flags);
      pixel_overrun_flag  <= ovr_set | (pixel_overrun_flag  & ~clear_flags);
      sequence_error_flag <= seq_set | (sequence_error_flag & ~clear_flags);
    end
  end

endmodule

// File: tb/tb_image_packer.sv
// tb/tb_image_packer.sv - scoreboard bench for image_packer
module tb_image_packer;
  logic        sysClk = 1'b0;
  logic        sysRst_n = 1'b0;
  logic [11:0] image_pixel_data = 12'h000;
  logic        image_data_valid = 1'b0;
  logic        image_metadata_line = 1'b0;
  logic        image_metadata_valid = 1'b0;
  logic        image_frame_end = 1'b0;
  logic        clear_flags = 1'b0;
  logic        frame_active, fifo_overflow_flag, pixel_overrun_flag, sequence_error_flag;

  image_packer_if out_if();

  image_packer #(.FIFO_DEPTH(16)) dut (
    .sysClk              (sysClk),
    .sysRst_n            (sysRst_n),
    .image_pixel_data    (image_pixel_data),
    .image_data_valid    (image_data_valid),
    .image_metadata_line (image_metadata_line),
    .image_metadata_valid(image_metadata_valid),
    .image_frame_end     (image_frame_end),
    .clear_flags         (clear_flags),
    .out_if              (out_if),
    .frame_active        (frame_active),
    .fifo_overflow_flag  (fifo_overflow_flag),
    .pixel_overrun_flag  (pixel_overrun_flag),
    .sequence_error_flag (sequence_error_flag)
  );

  always #5 sysClk = ~sysClk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         pop_cnt = 0;
  logic [9:0] sb[$];
  bit         sb_cap = 1'b0;
  logic [7:0] m_crc;
  bit         m_half;
  logic [3:0] m_nib;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge sysClk) begin
    if (out_if.out_valid && out_if.out_ready) begin
      pop_cnt++;
      if (sb.size() == 0) check("sb_has_entry", 32'(sb.size()), 32'd1);
      else check("out_word", {22'h0, out_if.out_eof, out_if.out_sof, out_if.out_data},
                 {22'h0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  task automatic exp_byte(input logic [7:0] b, input bit sof, input bit eof);
    m_crc = crc_step(m_crc, b);
    if (!sb_cap || sb.size() < 16) sb.push_back({eof, sof, b});
  endtask

  task automatic send_meta(input logic [47:0] m, input int nbits);
    for (int i = 47; i > 47 - nbits; i--) begin
      image_metadata_line  = m[i];
      image_metadata_valid = 1'b1;
      tick();
    end
    image_metadata_valid = 1'b0;
    image_metadata_line  = 1'b0;
  endtask

  task automatic start_frame(input logic [47:0] m);
    m_crc = 8'h00; m_half = 1'b0; m_cnt = 0; m_nib = 4'h0;
    send_meta(m, 48);
    exp_byte(8'hA5, 1'b1, 1'b0);
    exp_byte(8'h5A, 1'b0, 1'b0);
    for (int i = 5; i >= 0; i--) exp_byte(m[i*8 +: 8], 1'b0, 1'b0);
    repeat (8) tick();
  endtask

  task automatic model_pixel(input logic [11:0] p);
    if (!m_half) begin
      exp_byte(p[11:4], 1'b0, 1'b0);
      m_nib  = p[3:0];
      m_half = 1'b1;
    end else begin
      exp_byte({m_nib, p[11:8]}, 1'b0, 1'b0);
      exp_byte(p[7:0], 1'b0, 1'b0);
      m_half = 1'b0;
    end
    m_cnt++;
  endtask

  task automatic send_pixel(input logic [11:0] p);
    model_pixel(p);
    image_pixel_data = p; image_data_valid = 1'b1;
    tick();
    image_data_valid = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    logic [23:0] c;
    bit crc_en;
    image_frame_end = 1'b1;
    tick();
    image_frame_end = 1'b0;
`ifdef IMAGE_PACKER_CRC_EN
    crc_en = 1'b1;
`else
    crc_en = 1'b0;
`endif
    c = 24'(m_cnt);
    if (m_half) exp_byte({m_nib, 4'h0}, 1'b0, 1'b0);
    exp_byte(8'h5A, 1'b0, 1'b0);
    exp_byte(8'hA5, 1'b0, 1'b0);
    exp_byte(c[23:16], 1'b0, 1'b0);
    exp_byte(c[15:8], 1'b0, 1'b0);
    exp_byte(c[7:0], 1'b0, !crc_en);
    if (crc_en) exp_byte(m_crc, 1'b0, 1'b1);
    repeat (8) tick();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    repeat (2) tick();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"}, {24'h0, out_if.out_valid, out_if.out_sof, out_if.out_eof,
          frame_active, fifo_overflow_flag, pixel_overrun_flag, sequence_error_flag, 1'b0}, 32'h0);
    check({tag, "_data"}, 32'(out_if.out_data), 32'h0);
  endtask

  initial begin
    int p0;
    out_if.out_ready = 1'b1;
    repeat (3) @(posedge sysClk);
    #1;
    check_reset_outputs("reset");
    sysRst_n = 1'b1;
    tick();

    // Reference frame: two pixels, even count
    start_frame(48'h8123_4567_BEEF);
    check("active_pix", 32'(frame_active), 32'd1);
    send_pixel(12'hABC);
    send_pixel(12'h123);
    end_frame();
    wait_drain("drain_ref");
    check("idle_after_ref", 32'(frame_active), 32'd0);

    // Odd count: pad nibble then count 1
    start_frame(48'h0000_0000_0001);
    send_pixel(12'hFED);
    end_frame();
    wait_drain("drain_odd");

    // Back-to-back strobes: second one dropped
    start_frame(48'h7FFF_0000_1234);
    model_pixel(12'h456);
    image_pixel_data = 12'h456; image_data_valid = 1'b1;
    tick();
    image_pixel_data = 12'h789;
    tick();
    image_data_valid = 1'b0;
    tick();
    check("overrun_flag", 32'(pixel_overrun_flag), 32'd1);
    send_pixel(12'h0F0);
    send_pixel(12'hF0F);
    end_frame();
    wait_drain("drain_overrun");
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check("overrun_cleared", 32'(pixel_overrun_flag), 32'd0);

    // Aborted metadata
    check("seq_before", 32'(sequence_error_flag), 32'd0);
    send_meta(48'hFFFF_FFFF_FFFF, 20);
    check("active_meta", 32'(frame_active), 32'd1);
    image_frame_end = 1'b1; tick(); image_frame_end = 1'b0;
    tick();
    check("abort_idle", 32'(frame_active), 32'd0);
    check("abort_seq", 32'(sequence_error_flag), 32'd1);
    check("abort_nobytes", 32'(out_if.out_valid), 32'd0);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check("seq_cleared", 32'(sequence_error_flag), 32'd0);

    // Overflow: consumer stalled over a frame longer than the FIFO
    out_if.out_ready = 1'b0;
    sb_cap = 1'b1;
    start_frame(48'hC0DE_CAFE_0102);
    for (int i = 0; i < 5; i++) send_pixel(12'(12'h111 * (i + 1)));
    end_frame();
    check("ovf_flag", 32'(fifo_overflow_flag), 32'd1);
    check("ovf_idle", 32'(frame_active), 32'd0);
    check("ovf_sb16", 32'(sb.size()), 32'd16);
    sb_cap = 1'b0;
    p0 = pop_cnt;
    out_if.out_ready = 1'b1;
    repeat (40) tick();
    check("ovf_drained", 32'(pop_cnt - p0), 32'd16);
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-PIX, then a clean frame
    start_frame(48'h1357_9BDF_2468);
    send_pixel(12'h321);
    image_pixel_data = 12'h654; image_data_valid = 1'b1;
    tick();
    image_data_valid = 1'b0;
    sysRst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    repeat (2) tick();
    sysRst_n = 1'b1;
    tick();
    start_frame(48'hA5A5_5A5A_00FF);
    send_pixel(12'h800);
    send_pixel(12'h00F);
    send_pixel(12'hFFF);
    end_frame();
    wait_drain("drain_post_rst");
    check("post_rst_flags", {29'h0, fifo_overflow_flag, pixel_overrun_flag, sequence_error_flag}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=finished", n_checks);
    $fatal(1, "timeout");
  end

endmodule
